// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer: control FSM for a UART receive shift-register datapath.
// Synchronises and oversamples serial_in, validates the start bit and issues
// one mid-bit shift strobe per data bit. It then checks the stop bit, loads the
// holding register, and runs the data_rdy/data_ack handshake with overrun status.
//
// Ports
//   clock        rising-edge system clock
//   reset        asynchronous, active-low
//   serial_in    raw UART line (idles high)
//   shift_en     1-cycle strobe: datapath shifts shift_bit in at its MSB end
//   shift_bit    synchronised line value sampled at mid-bit
//   load_en      1-cycle strobe: datapath copies shift register to holding register
//   data_rdy     holding register valid
//   data_ack     consumer accepts data (only effective while data_rdy=1)
//   framing_err  1-cycle pulse: stop bit sampled low
//   overrun      sticky: a frame was loaded over an unacknowledged word
module uart_rx_sequencer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic serial_in,
  output logic shift_en,
  output logic shift_bit,
  output logic load_en,
  output logic data_rdy,
  input  logic data_ack,
  output logic framing_err,
  output logic overrun
);

  localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

  localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state;
  logic [TMR_W-1:0]       timer;
  logic [CNT_W-1:0]       bit_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Line synchroniser; resets to the idle (high) level so reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
    end
  end

  // Frame sequencer: start validation, mid-bit shift strobes, stop check.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      bit_cnt     <= '0;
      shift_en    <= 1'b0;
      shift_bit   <= 1'b1;
      load_en     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      shift_en    <= 1'b0;
      load_en     <= 1'b0;
      framing_err <= 1'b0;

      case (state)
        S_IDLE: begin
          timer   <= '0;
          bit_cnt <= '0;
          if (!rx_s) begin
            state <= S_START;
          end
        end

        // Re-check the line half a bit in to reject glitches.
        S_START: begin
          if (timer == HALF_LAST) begin
            timer <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        // Timer now runs aligned to mid-bit, so each wrap is a sample point.
        S_DATA: begin
          if (timer == BIT_LAST) begin
            timer     <= '0;
            shift_en  <= 1'b1;
            shift_bit <= rx_s;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        S_STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            if (rx_s) begin
              load_en <= 1'b1;
              state   <= S_IDLE;
            end else begin
              framing_err <= 1'b1;
              state       <= S_BREAK;
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        // Wait out a held-low line so it cannot retrigger a frame.
        S_BREAK: begin
          timer   <= '0;
          bit_cnt <= '0;
          if (rx_s) begin
            state <= S_IDLE;
          end
        end

        default: begin
          timer   <= '0;
          bit_cnt <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // Consumer handshake; a load coinciding with an accepted ack is a fresh word, not an overrun.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_rdy <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (load_en) begin
        data_rdy <= 1'b1;
      end else if (data_ack && data_rdy) begin
        data_rdy <= 1'b0;
      end

      if (load_en && data_rdy && !data_ack) begin
        overrun <= 1'b1;
      end else if (data_ack && data_rdy) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
